uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter_pkg.sv | 17 +
 rtl/uart_tx_serializer.sv | 76 +++++++
 rtl/uart_tx_arbiter.sv | 146 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the UART transmit arbiter and its serializer.
package uart_tx_arbiter_pkg;

   typedef enum logic {
      StIdle,
      StLocked
   } arb_state_e;

   // 8N1 frame: start + 8 data + stop
   localparam int unsigned FrameBits = 10;

   function automatic int unsigned cycles_per_bit(input int unsigned clk_hz,
                                                  input int unsigned baud);
      return clk_hz / baud;
   endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// 8N1 serializer: accepts a byte when idle and shifts it out LSB first on tx_o.
module uart_tx_serializer
   import uart_tx_arbiter_pkg::*;
#(
   parameter int unsigned CyclesPerBit = 10
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       valid_i,
   input  logic [7:0] data_i,
   output logic       idle_o,
   output logic       tx_o
);

   localparam int unsigned CntW = (CyclesPerBit > 1) ? $clog2(CyclesPerBit) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(CyclesPerBit - 1);
   localparam logic [3:0] BitLast = 4'(FrameBits - 1);

   logic            active_q, active_d;
   logic [3:0]      bit_q, bit_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [8:0]      shift_q, shift_d;
   logic            tx_q, tx_d;
   logic            bit_end;

   assign bit_end = (cnt_q == CntLast);
   // Idle already on the final stop-bit cycle so a follow-on byte starts with no gap.
   assign idle_o  = !active_q || (bit_end && (bit_q == BitLast));
   assign tx_o    = tx_q;

   always_comb begin
      active_d = active_q;
      bit_d    = bit_q;
      cnt_d    = cnt_q;
      shift_d  = shift_q;
      tx_d     = tx_q;
      if (valid_i && idle_o) begin
         active_d = 1'b1;
         bit_d    = '0;
         cnt_d    = '0;
         shift_d  = {1'b1, data_i};
         tx_d     = 1'b0;
      end else if (active_q) begin
         if (bit_end) begin
            cnt_d = '0;
            if (bit_q == BitLast) begin
               active_d = 1'b0;
               tx_d     = 1'b1;
            end else begin
               bit_d   = bit_q + 4'd1;
               tx_d    = shift_q[0];
               shift_d = {1'b1, shift_q[8:1]};
            end
         end else begin
            cnt_d = cnt_q + CntW'(1);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         active_q <= 1'b0;
         bit_q    <= '0;
         cnt_q    <= '0;
         shift_q  <= '1;
         tx_q     <= 1'b1;
      end else begin
         active_q <= active_d;
         bit_q    <= bit_d;
         cnt_q    <= cnt_d;
         shift_q  <= shift_d;
         tx_q     <= tx_d;
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter granting one byte-stream requester at a time onto a shared UART line,
// with the grant held for a whole message and revoked after an idle timeout.
module uart_tx_arbiter
   import uart_tx_arbiter_pkg::*;
#(
   parameter int unsigned CLOCK_FREQUENCY = 50000000,
   parameter int unsigned UART_BAUD_RATE  = 9600,
   parameter int unsigned NUM_REQUESTERS  = 4,
   parameter int unsigned LOCK_TIMEOUT    = 65536
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic [NUM_REQUESTERS-1:0]   req_valid,
   input  logic [8*NUM_REQUESTERS-1:0] req_data,
   input  logic [NUM_REQUESTERS-1:0]   req_last,
   output logic [NUM_REQUESTERS-1:0]   req_ready,
   output logic                        uart_tx,
   output logic                        busy,
   output logic [2:0]                  grant_id
);

   localparam int unsigned CyclesPerBit = cycles_per_bit(CLOCK_FREQUENCY, UART_BAUD_RATE);
   localparam int unsigned TmoW = 21;
   localparam logic [TmoW-1:0] TmoLast = TmoW'(LOCK_TIMEOUT - 1);
   localparam logic [2:0] LastIdx = 3'(NUM_REQUESTERS - 1);

   arb_state_e                  state_q, state_d;
   logic [2:0]                  grant_q, grant_d;
   logic [2:0]                  rr_q, rr_d;
   logic [TmoW-1:0]             tmo_q, tmo_d;
   logic [2:0]                  pick, next_ptr;
   logic [3:0]                  pick_sum;
   logic                        any_valid;
   logic [2*NUM_REQUESTERS-1:0] valid_dbl, valid_shift;
   logic [NUM_REQUESTERS-1:0]   valid_rot;
   logic                        ser_idle, accept;
   logic                        g_valid, g_last;
   logic [7:0]                  g_data;

   always_comb begin
      g_valid = 1'b0;
      g_last  = 1'b0;
      g_data  = '0;
      for (int unsigned i = 0; i < NUM_REQUESTERS; i++) begin
         if (grant_q == 3'(i)) begin
            g_valid = req_valid[i];
            g_last  = req_last[i];
            g_data  = req_data[8*i +: 8];
         end
      end
   end

   // Rotate so bit 0 is requester rr_q, then take the lowest set bit.
   assign valid_dbl   = {req_valid, req_valid};
   assign valid_shift = valid_dbl >> rr_q;
   assign valid_rot   = valid_shift[NUM_REQUESTERS-1:0];

   always_comb begin
      pick      = rr_q;
      pick_sum  = '0;
      any_valid = 1'b0;
      for (int unsigned k = 0; k < NUM_REQUESTERS; k++) begin
         if (!any_valid && valid_rot[k]) begin
            any_valid = 1'b1;
            pick_sum  = {1'b0, rr_q} + 4'(k);
            if (pick_sum >= 4'(NUM_REQUESTERS)) begin
               pick_sum = pick_sum - 4'(NUM_REQUESTERS);
            end
            pick = pick_sum[2:0];
         end
      end
   end

   assign next_ptr = (grant_q == LastIdx) ? 3'd0 : grant_q + 3'd1;
   assign accept   = (state_q == StLocked) && g_valid && ser_idle;

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      rr_d    = rr_q;
      tmo_d   = tmo_q;
      unique case (state_q)
         StIdle: begin
            if (any_valid) begin
               state_d = StLocked;
               grant_d = pick;
               tmo_d   = '0;
            end
         end
         StLocked: begin
            if (accept) begin
               tmo_d = '0;
               if (g_last) begin
                  state_d = StIdle;
                  rr_d    = next_ptr;
               end
            end else if (ser_idle && !g_valid) begin
               if (tmo_q == TmoLast) begin
                  state_d = StIdle;
                  rr_d    = next_ptr;
                  tmo_d   = '0;
               end else begin
                  tmo_d = tmo_q + TmoW'(1);
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         grant_q <= '0;
         rr_q    <= '0;
         tmo_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         rr_q    <= rr_d;
         tmo_q   <= tmo_d;
      end
   end

   always_comb begin
      req_ready = '0;
      for (int unsigned i = 0; i < NUM_REQUESTERS; i++) begin
         req_ready[i] = (state_q == StLocked) && ser_idle && (grant_q == 3'(i));
      end
   end

   assign busy     = (state_q == StLocked) || !ser_idle;
   assign grant_id = grant_q;

   uart_tx_serializer #(
      .CyclesPerBit(CyclesPerBit)
   ) u_serializer (
      .clk_i  (clock),
      .rst_ni (reset),
      .valid_i(accept),
      .data_i (g_data),
      .idle_o (ser_idle),
      .tx_o   (uart_tx)
   );

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench: message-level reference model predicts grants, handshakes and the serial
// waveform; a monitor decodes uart_tx frames and checks them against the expected bytes.
module tb_uart_tx_arbiter;

   localparam int unsigned ClkHz    = 1000000;
   localparam int unsigned Baud     = 100000;
   localparam int          NReq     = 4;
   localparam int          Tmo      = 50;
   localparam int          Cpb      = 10;
   localparam int          FrameCyc = 10 * Cpb;

   logic                 clock = 1'b0;
   logic                 reset;
   logic [NReq-1:0]      req_valid;
   logic [8*NReq-1:0]    req_data;
   logic [NReq-1:0]      req_last;
   logic [NReq-1:0]      req_ready;
   logic                 uart_tx;
   logic                 busy;
   logic [2:0]           grant_id;

   uart_tx_arbiter #(
      .CLOCK_FREQUENCY(ClkHz),
      .UART_BAUD_RATE (Baud),
      .NUM_REQUESTERS (NReq),
      .LOCK_TIMEOUT   (Tmo)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .req_valid(req_valid),
      .req_data (req_data),
      .req_last (req_last),
      .req_ready(req_ready),
      .uart_tx  (uart_tx),
      .busy     (busy),
      .grant_id (grant_id)
   );

   always #5 clock = ~clock;

   int         checks = 0;
   int         failures = 0;
   logic [8:0] src_q[NReq][$];   // {last, byte} per requester
   bit         en[NReq];
   int         pause[NReq];
   bit         rand_mode = 0;
   bit         mon_en = 0;
   int         cyc = 0;
   logic [7:0] exp_q[$];
   int         acc_req[$];
   int         acc_cyc[$];

   // Reference model: grant owner, round-robin pointer, idle count, frame cycles remaining
   bit         m_locked;
   int         m_g, m_rr, m_tmo, m_left;
   logic [7:0] m_byte;

   task automatic model_reset();
      m_locked = 0; m_g = 0; m_rr = 0; m_tmo = 0; m_left = 0; m_byte = 8'h00;
   endtask

   function automatic logic model_tx(input int left, input logic [7:0] b);
      int bi;
      if (left == 0) return 1'b1;
      bi = (FrameCyc - left) / Cpb;
      if (bi == 0) return 1'b0;
      if (bi == 9) return 1'b1;
      return b[bi-1];
   endfunction

   function automatic bit pending();
      for (int i = 0; i < NReq; i++) if (src_q[i].size() > 0) return 1;
      return 0;
   endfunction

   task automatic model_step();
      bit idle;
      int j;
      if (!reset) begin
         model_reset();
         return;
      end
      idle = (m_left <= 1);
      if (!m_locked) begin
         for (int k = 0; k < NReq; k++) begin
            j = (m_rr + k) % NReq;
            if (!m_locked && req_valid[j]) begin
               m_locked = 1; m_g = j; m_tmo = 0;
            end
         end
         if (m_left > 0) m_left--;
      end else if (req_valid[m_g] && idle) begin
         m_byte = req_data[8*m_g +: 8];
         exp_q.push_back(m_byte);
         void'(src_q[m_g].pop_front());
         m_left = FrameCyc;
         m_tmo  = 0;
         if (req_last[m_g]) begin
            m_locked = 0; m_rr = (m_g + 1) % NReq;
         end
      end else begin
         if (idle && !req_valid[m_g]) begin
            m_tmo++;
            if (m_tmo == Tmo) begin
               m_locked = 0; m_rr = (m_g + 1) % NReq; m_tmo = 0;
            end
         end
         if (m_left > 0) m_left--;
      end
   endtask

   task automatic drive();
      logic [8:0] h;
      for (int i = 0; i < NReq; i++) begin
         if (rand_mode) begin
            if (pause[i] > 0) pause[i]--;
            else if ($urandom_range(0, 299) == 0) pause[i] = $urandom_range(40, 80);
            en[i] = (pause[i] == 0) && ($urandom_range(0, 3) != 0);
         end
         if (en[i] && src_q[i].size() > 0) begin
            h = src_q[i][0];
            req_valid[i] = 1'b1;
            req_data[8*i +: 8] = h[7:0];
            req_last[i] = h[8];
         end else begin
            req_valid[i] = 1'b0;
            req_data[8*i +: 8] = 8'($urandom);
            req_last[i] = 1'($urandom);
         end
      end
   endtask

   task automatic check_cycle();
      logic [NReq-1:0] er;
      logic            eb, et;
      er = '0;
      if (m_locked && m_left <= 1) er[m_g] = 1'b1;
      eb = m_locked || (m_left > 1);
      et = model_tx(m_left, m_byte);
      checks++;
      if (req_ready !== er || busy !== eb || grant_id !== 3'(m_g) || uart_tx !== et) begin
         failures++;
         $display("FAIL cycle_outputs @%0d: ready=%b busy=%b grant=%0d tx=%b, required ready=%b busy=%b grant=%0d tx=%b",
                  cyc, req_ready, busy, grant_id, uart_tx, er, eb, m_g, et);
      end
   endtask

   task automatic step();
      @(posedge clock);
      model_step();
      cyc++;
      @(negedge clock);
      check_cycle();
      drive();
      for (int i = 0; i < NReq; i++) begin
         if (req_valid[i] && req_ready[i]) begin
            acc_req.push_back(i);
            acc_cyc.push_back(cyc);
         end
      end
   endtask

   task automatic run_until_idle(input int budget, input string name);
      int n;
      n = 0;
      while ((pending() || m_locked || m_left > 0) && n < budget) begin
         step();
         n++;
      end
      checks++;
      if (n >= budget) begin
         failures++;
         $display("FAIL %s: still active after %0d cycles, required idle", name, n);
      end
   endtask

   function automatic int acc_at(input int i);
      if (i < acc_req.size()) return acc_req[i];
      return -1;
   endfunction

   function automatic int gap(input int i);
      if (i + 1 < acc_cyc.size()) return acc_cyc[i+1] - acc_cyc[i];
      return -1;
   endfunction

   task automatic chk_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d, required %0d", name, act, exp);
      end
   endtask

   // Serial monitor: decodes each frame mid-bit and pops the scoreboard.
   initial begin
      logic [7:0] b;
      logic [7:0] e;
      logic       st, sp;
      forever begin
         @(posedge clock); #1;
         if (mon_en && reset && uart_tx === 1'b0) begin
            repeat (Cpb / 2 - 1) begin @(posedge clock); #1; end
            st = uart_tx;
            for (int k = 0; k < 8; k++) begin
               repeat (Cpb) begin @(posedge clock); #1; end
               b[k] = uart_tx;
            end
            repeat (Cpb) begin @(posedge clock); #1; end
            sp = uart_tx;
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL serial_frame: got byte %02h, required no frame", b);
            end else begin
               e = exp_q.pop_front();
               if (b !== e || st !== 1'b0 || sp !== 1'b1) begin
                  failures++;
                  $display("FAIL serial_frame: got byte %02h start=%b stop=%b, required %02h start=0 stop=1",
                           b, st, sp, e);
               end
            end
         end
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int base, nmsg, len;
      req_valid = '0; req_data = '0; req_last = '0;
      for (int i = 0; i < NReq; i++) begin en[i] = 1; pause[i] = 0; end
      model_reset();
      reset = 1'b1;
      #1 reset = 1'b0;
      repeat (3) @(negedge clock);
      checks++;
      if (uart_tx !== 1'b1 || busy !== 1'b0 || req_ready !== '0 || grant_id !== 3'd0) begin
         failures++;
         $display("FAIL reset_state: tx=%b busy=%b ready=%b grant=%0d, required tx=1 busy=0 ready=0 grant=0",
                  uart_tx, busy, req_ready, grant_id);
      end
      mon_en = 1;

      // Single 0x48 message from requester 0
      src_q[0].push_back({1'b1, 8'h48});
      drive();
      reset = 1'b1;
      run_until_idle(400, "t1_single");
      chk_int("t1_grant", acc_at(0), 0);

      // rr_ptr becomes 2, then requesters 1 and 3 contend
      src_q[1].push_back({1'b1, 8'h11});
      drive();
      run_until_idle(400, "t2_setup");
      src_q[1].push_back({1'b1, 8'h22});
      src_q[3].push_back({1'b1, 8'h33});
      drive();
      run_until_idle(800, "t2_contend");
      chk_int("t2_setup_grant", acc_at(1), 1);
      chk_int("t2_first_grant", acc_at(2), 3);
      chk_int("t2_second_grant", acc_at(3), 1);

      // Three-byte message holds the line against requester 0
      src_q[0].push_back({1'b1, 8'h30});
      src_q[2].push_back({1'b0, 8'h61});
      src_q[2].push_back({1'b0, 8'h62});
      src_q[2].push_back({1'b1, 8'h63});
      drive();
      run_until_idle(1200, "t3_message");
      chk_int("t3_grant_a", acc_at(4), 2);
      chk_int("t3_grant_b", acc_at(5), 2);
      chk_int("t3_grant_c", acc_at(6), 2);
      chk_int("t3_grant_after", acc_at(7), 0);
      chk_int("t3_gap_ab", gap(4), FrameCyc);
      chk_int("t3_gap_bc", gap(5), FrameCyc);

      // Lock timeout: requester 1 stalls mid-message, requester 2 waits
      src_q[1].push_back({1'b0, 8'h5A});
      src_q[2].push_back({1'b1, 8'h77});
      drive();
      run_until_idle(1000, "t4_timeout");
      chk_int("t4_first", acc_at(8), 1);
      chk_int("t4_next", acc_at(9), 2);
      checks++;
      if (gap(8) < FrameCyc + Tmo || gap(8) > FrameCyc + Tmo + 2) begin
         failures++;
         $display("FAIL t4_timeout_gap: got %0d cycles, required %0d..%0d",
                  gap(8), FrameCyc + Tmo, FrameCyc + Tmo + 2);
      end

      // Randomized messages with random valid gaps and occasional long stalls
      for (int i = 0; i < NReq; i++) begin
         nmsg = $urandom_range(2, 4);
         for (int m = 0; m < nmsg; m++) begin
            len = $urandom_range(1, 4);
            for (int k = 0; k < len; k++) src_q[i].push_back({1'(k == len - 1), 8'($urandom)});
         end
      end
      rand_mode = 1;
      drive();
      run_until_idle(60000, "random_drain");
      rand_mode = 0;
      for (int i = 0; i < NReq; i++) begin en[i] = 1; pause[i] = 0; end
      repeat (10) step();
      chk_int("scoreboard_empty", exp_q.size(), 0);

      // Reset mid-frame
      mon_en = 0;
      base = acc_req.size();
      src_q[3].push_back({1'b1, 8'hA5});
      drive();
      len = 0;
      while (acc_req.size() == base && len < 50) begin step(); len++; end
      chk_int("t5_accept", acc_at(base), 3);
      repeat (37) step();
      #2 reset = 1'b0;
      #1;
      checks++;
      if (uart_tx !== 1'b1 || busy !== 1'b0 || req_ready !== '0) begin
         failures++;
         $display("FAIL t5_reset_abort: tx=%b busy=%b ready=%b, required tx=1 busy=0 ready=0",
                  uart_tx, busy, req_ready);
      end
      model_reset();
      for (int i = 0; i < NReq; i++) src_q[i].delete();
      drive();
      repeat (2) step();
      reset = 1'b1;
      base = acc_req.size();
      src_q[0].push_back({1'b1, 8'h3C});
      drive();
      run_until_idle(400, "t5_fresh");
      chk_int("t5_fresh_grant", acc_at(base), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
